// File: rtl/systolic_output_collector.sv
// De-skews the bottom-row partial-sum stream of the systolic array into whole rows and buffers them in a small FIFO.
// Optional build macro SYSTOLIC_COLLECTOR_ALIGN_CHECK_EN enables aligned-valid consistency checking (align_err).
module systolic_output_collector #(
    parameter int N          = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr,
    input  logic [N-1:0]                         col_valid,
    input  logic [N*DATA_W-1:0]                  col_data,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [N*DATA_W-1:0]                  res_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
    output logic                                 overflow,
    output logic                                 align_err
);

    localparam int RW = N * DATA_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [RW-1:0] al_data;
    logic          push_req;
`ifdef SYSTOLIC_COLLECTOR_ALIGN_CHECK_EN
    logic [N-1:0]  al_valid;
    logic          mixed;
`endif

    // Column j is delayed N-1-j cycles so every column of a row lines up with column N-1.
    for (genvar j = 0; j < N - 1; j++) begin : g_col
        localparam int D = N - 1 - j;

        logic [DATA_W-1:0] dat_q [D];
        logic [DATA_W-1:0] dat_d [D];

        always_comb begin
            dat_d[0] = clr ? '0 : col_data[j*DATA_W +: DATA_W];
            for (int k = 1; k < D; k++) begin
                dat_d[k] = clr ? '0 : dat_q[k-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < D; k++) begin
                    dat_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < D; k++) begin
                    dat_q[k] <= dat_d[k];
                end
            end
        end

        assign al_data[j*DATA_W +: DATA_W] = dat_q[D-1];

`ifdef SYSTOLIC_COLLECTOR_ALIGN_CHECK_EN
        logic [D-1:0] vld_q;
        logic [D-1:0] vld_d;

        always_comb begin
            vld_d[0] = clr ? 1'b0 : col_valid[j];
            for (int k = 1; k < D; k++) begin
                vld_d[k] = clr ? 1'b0 : vld_q[k-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign al_valid[j] = vld_q[D-1];
`endif
    end

    assign al_data[(N-1)*DATA_W +: DATA_W] = col_data[(N-1)*DATA_W +: DATA_W];

`ifdef SYSTOLIC_COLLECTOR_ALIGN_CHECK_EN
    assign al_valid[N-1] = col_valid[N-1];
    assign push_req      = &al_valid;
    assign mixed         = (|al_valid) && !push_req;
`else
    // Only the last column's valid gates a push; the others are not delayed at all.
    logic unused_col_valid;
    assign push_req         = col_valid[N-1];
    assign unused_col_valid = ^col_valid[N-2:0];
`endif

    // Downstream handshake: a row transfers on any rising edge where res_valid && res_ready;
    // res_data is held steady while res_valid=1 and res_ready=0, and reads 0 when res_valid=0.
    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [RW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full    = (count_q == LW'(FIFO_DEPTH));
    assign pop     = valid_q && res_ready;
    assign do_push = push_req && (!full || pop);

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = al_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + LW'(do_push) - LW'(pop);
            if (push_req && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SYSTOLIC_COLLECTOR_ALIGN_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = 1'b0;
        end else if (mixed) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign align_err = err_q;
`else
    assign align_err = 1'b0;
`endif

    assign res_valid = valid_q;
    assign res_data  = valid_q ? mem_q[rd_ptr_q] : '0;
    assign level     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed plus randomized bench for systolic_output_collector against a row-queue reference model.
module tb_systolic_output_collector;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);
    localparam int RW = N * DW;
    localparam int HIST = 4096;

    logic          clk;
    logic          rst;
    logic          clr;
    logic [N-1:0]  col_valid;
    logic [RW-1:0] col_data;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic          align_err;

    systolic_output_collector #(.N(N), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .col_valid (col_valid),
        .col_data  (col_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .level     (level),
        .overflow  (overflow),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: rows indexed by the cycle their column 0 is driven, plus a queue of buffered rows.
    logic [RW-1:0] exp_q[$];
    bit            used [HIST];
    logic [RW-1:0] rdata [HIST];
    logic [N-1:0]  rmask [HIST];
    bit            m_ovf;
    bit            m_err;
    int            cyc;

    bit            t_start;
    logic [RW-1:0] t_data;
    logic [N-1:0]  t_mask;
    bit            t_ready;
    bit            t_clr;
    bit            t_rst;

    int n_cmp;
    int n_err;

    logic [RW-1:0] rows [8];

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [RW-1:0] e_data;
        int            a;
        int            s;
        bit            push;
        bit            mixed;
        bit            pop;
        e_data = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("res_valid", res_valid, RW'(exp_q.size() > 0));
        chk("res_data", res_data, e_data);
        chk("level", level, RW'(exp_q.size()));
        chk("overflow", overflow, RW'(m_ovf));
        chk("align_err", align_err, RW'(m_err));

        if (t_start) begin
            used[cyc]  = 1'b1;
            rdata[cyc] = t_data;
            rmask[cyc] = t_mask;
        end
        for (int j = 0; j < N; j++) begin
            s = cyc - j;
            if (s >= 0 && used[s]) begin
                col_valid[j]          = rmask[s][j];
                col_data[j*DW +: DW] = rdata[s][j*DW +: DW];
            end else begin
                col_valid[j]          = 1'b0;
                col_data[j*DW +: DW] = DW'($urandom);
            end
        end
        clr       = t_clr;
        res_ready = t_ready;
        rst       = ~t_rst;

        a     = cyc - (N - 1);
        push  = 1'b0;
        mixed = 1'b0;
        if (a >= 0 && used[a]) begin
`ifdef SYSTOLIC_COLLECTOR_ALIGN_CHECK_EN
            push  = (rmask[a] == '1);
            mixed = !push && (rmask[a] != '0);
`else
            push  = rmask[a][N-1];
`endif
        end
        if (t_rst || t_clr) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_err = 1'b0;
            for (int k = cyc - (N - 1); k <= cyc; k++) begin
                if (k >= 0) used[k] = 1'b0;
            end
        end else begin
            pop = (exp_q.size() > 0) && t_ready;
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (exp_q.size() < D) exp_q.push_back(rdata[a]);
                else m_ovf = 1'b1;
            end
            if (mixed) m_err = 1'b1;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
        t_start = 1'b0;
    endtask

    task automatic send_row(input logic [RW-1:0] data, input logic [N-1:0] mask);
        t_start = 1'b1;
        t_data  = data;
        t_mask  = mask;
        tick();
    endtask

    task automatic clear_once();
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        m_ovf = 0; m_err = 0;
        t_start = 0; t_data = '0; t_mask = '0; t_ready = 0; t_clr = 0; t_rst = 1;
        rst = 1'b0; clr = 1'b0; res_ready = 1'b0; col_valid = '0; col_data = '0;
        for (int i = 0; i < HIST; i++) used[i] = 1'b0;

        @(negedge clk);
        chk("reset_valid", res_valid, '0);
        chk("reset_data", res_data, '0);
        chk("reset_level", level, '0);
        chk("reset_flags", {overflow, align_err}, '0);
        tick();
        tick();
        t_rst = 0;

        // Single row latency and packing.
        t_ready = 1;
        repeat (5) tick();
        send_row(32'h44332211, '1);
        repeat (N - 1) tick();
        chk("t1_valid", res_valid, 1);
        chk("t1_data", res_data, 32'h44332211);
        tick();
        chk("t1_level", level, 0);

        // Six back-to-back rows into a stalled FIFO: four kept, two dropped.
        t_ready = 0;
        for (int i = 0; i < 6; i++) begin
            rows[i] = $urandom;
            send_row(rows[i], '1);
        end
        repeat (N + 1) tick();
        chk("t2_level", level, D);
        chk("t2_ovf", overflow, 1);
        t_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", res_data, rows[i]);
            tick();
        end
        chk("t2_empty", res_valid, 0);

        // Full FIFO with a simultaneous push and pop.
        clear_once();
        t_ready = 0;
        for (int i = 0; i < 5; i++) begin
            rows[i] = $urandom;
            send_row(rows[i], '1);
        end
        repeat (N - 2) tick();
        t_ready = 1;
        tick();
        t_ready = 0;
        tick();
        chk("t3_level", level, D);
        chk("t3_ovf", overflow, 0);
        t_ready = 1;
        for (int i = 1; i < 5; i++) begin
            chk("t3_order", res_data, rows[i]);
            tick();
        end

        // Column 2 suppressed for one row, then a clean row.
        clear_once();
        t_ready = 1;
        send_row($urandom, 4'b1011);
        send_row($urandom, '1);
        repeat (N + 2) tick();
`ifdef SYSTOLIC_COLLECTOR_ALIGN_CHECK_EN
        chk("t4_align_err", align_err, 1);
`else
        chk("t4_align_err", align_err, 0);
`endif

        // Reset with two rows buffered and one in flight.
        clear_once();
        t_ready = 0;
        send_row($urandom, '1);
        send_row($urandom, '1);
        tick();
        tick();
        send_row($urandom, '1);
        chk("t5_pre_level", level, 2);
        t_rst = 1;
        tick();
        t_rst = 0;
        repeat (N + 3) tick();
        chk("t5_level", level, 0);
        chk("t5_valid", res_valid, 0);

        // clr with overflow set and three rows buffered.
        t_ready = 0;
        for (int i = 0; i < 5; i++) send_row($urandom, '1);
        repeat (N) tick();
        t_ready = 1;
        tick();
        t_ready = 0;
        chk("t6_level", level, 3);
        chk("t6_ovf", overflow, 1);
        clear_once();
        chk("t6_clr_level", level, 0);
        chk("t6_clr_valid", res_valid, 0);
        chk("t6_clr_ovf", overflow, 0);

        // Randomized traffic with occasional partial rows and clears.
        for (int i = 0; i < 400; i++) begin
            t_start = ($urandom_range(0, 1) == 1);
            t_data  = $urandom;
            t_mask  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            t_ready = ($urandom_range(0, 3) != 0);
            t_clr   = ($urandom_range(0, 49) == 0);
            tick();
        end
        t_clr   = 0;
        t_ready = 1;
        repeat (N + D + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
